// File: rtl/store_capture_fifo.sv
// store_capture_fifo
// Snoops the core's data-memory store port, keeps stores that fall inside
// [ADDR_LO, ADDR_HI], and queues {address, data} pairs for a valid/ready
// consumer. The head is first-word-fall-through. A store that arrives while
// the queue is full and no pop frees a slot is dropped. The drop sets a
// sticky flag and increments a saturating counter.
module store_capture_fifo #(
  parameter int unsigned DEPTH   = 8,
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   r_mem_addr [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;

  logic w_ge_lo;
  logic w_le_hi;
  logic w_hit;
  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A window bound at the end of the address range always passes. Resolving
  // it at elaboration avoids a comparison whose result is constant.
  generate
    if (ADDR_LO == 32'h0000_0000) begin : g_lo_open
      assign w_ge_lo = 1'b1;
    end else begin : g_lo_cmp
      assign w_ge_lo = (DataAdr >= ADDR_LO);
    end
    if (ADDR_HI == 32'hFFFF_FFFF) begin : g_hi_open
      assign w_le_hi = 1'b1;
    end else begin : g_hi_cmp
      assign w_le_hi = (DataAdr <= ADDR_HI);
    end
  endgenerate

  assign w_hit   = MemWrite & w_ge_lo & w_le_hi;
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = w_valid & out_ready;
  // When the queue is full, a same-cycle pop frees the slot the push needs.
  assign w_push  = w_hit & (~w_full | w_pop);
  assign w_drop  = w_hit & w_full & ~w_pop;

  // Pointers, occupancy and drop bookkeeping. A clear overrides any
  // coincident push or pop, and the discarded store is not counted as a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // Entry storage. It has no reset because its contents only matter behind
  // the valid pointers.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem_addr[r_wr_ptr] <= DataAdr;
      r_mem_data[r_wr_ptr] <= WriteData;
    end
  end

  assign out_valid = w_valid;
  assign out_addr  = w_valid ? r_mem_addr[r_rd_ptr] : 32'h0;
  assign out_data  = w_valid ? r_mem_data[r_rd_ptr] : 32'h0;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_store_capture_fifo.sv
// Bench for store_capture_fifo. One instance uses the default full-range
// window and is tracked by a queue scoreboard. A second instance uses a
// narrow window for the filtering case.
module tb_store_capture_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, clear, out_ready;
  logic [31:0] DataAdr, WriteData;
  logic        out_valid, overflow;
  logic [31:0] out_addr, out_data;
  logic [3:0]  count;
  logic [15:0] drop_cnt;

  logic        wn_mw, wn_clear, wn_ready;
  logic [31:0] wn_adr, wn_wd;
  logic        wn_valid, wn_ovf;
  logic [31:0] wn_addr, wn_data;
  logic [3:0]  wn_count;
  logic [15:0] wn_drop;

  logic [63:0] exp_q[$];
  bit          m_ovf;
  int          m_drop;
  logic [31:0] last_addr, last_data;
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  store_capture_fifo #(.DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  store_capture_fifo #(.DEPTH(DEPTH), .ADDR_LO(32'd96), .ADDR_HI(32'd103)) u_win (
    .clk(clk), .reset(reset), .MemWrite(wn_mw), .DataAdr(wn_adr),
    .WriteData(wn_wd), .clear(wn_clear), .out_valid(wn_valid),
    .out_ready(wn_ready), .out_addr(wn_addr), .out_data(wn_data),
    .count(wn_count), .overflow(wn_ovf), .drop_cnt(wn_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [63:0] h;
    h = (exp_q.size() != 0) ? exp_q[0] : 64'h0;
    chk({tag, ".count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, ".valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    chk({tag, ".addr"}, out_addr, h[63:32]);
    chk({tag, ".data"}, out_data, h[31:0]);
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".drop"}, 32'(drop_cnt), 32'(m_drop));
  endtask

  // One clock of stimulus. The scoreboard pops on a handshake, pushes an
  // accepted store, or records a drop.
  task automatic cycle(input bit mw, input logic [31:0] adr, input logic [31:0] wd,
                       input bit rdy, input bit clr);
    logic [63:0] e;
    @(negedge clk);
    MemWrite = mw; DataAdr = adr; WriteData = wd; out_ready = rdy; clear = clr;
    #1;
    if (clr) begin
      exp_q.delete();
      m_ovf  = 0;
      m_drop = 0;
    end else begin
      if (rdy && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pop.addr", out_addr, e[63:32]);
        chk("pop.data", out_data, e[31:0]);
        last_addr = out_addr;
        last_data = out_data;
      end
      if (mw) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({adr, wd});
        else begin
          m_ovf = 1;
          if (m_drop != 65535) m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
    MemWrite = 0; out_ready = 0; clear = 0;
    check_state("st");
  endtask

  task automatic wstore(input logic [31:0] adr, input logic [31:0] wd);
    @(negedge clk);
    wn_mw = 1; wn_adr = adr; wn_wd = wd;
    @(posedge clk);
    #1;
    wn_mw = 0;
  endtask

  initial begin
    reset = 1; MemWrite = 0; DataAdr = 0; WriteData = 0; clear = 0; out_ready = 0;
    wn_mw = 0; wn_adr = 0; wn_wd = 0; wn_clear = 0; wn_ready = 0;
    m_ovf = 0; m_drop = 0; last_addr = 0; last_data = 0;
    #12;
    check_state("reset");
    @(negedge clk);
    reset = 0;

    // Single store, FWFT head, then pop
    cycle(1, 32'd100, 32'd7, 0, 0);
    chk("t1.count", 32'(count), 32'd1);
    chk("t1.addr", out_addr, 32'd100);
    chk("t1.data", out_data, 32'd7);
    cycle(0, 0, 0, 1, 0);
    chk("t1.empty", 32'(out_valid), 32'd0);
    chk("t1.zaddr", out_addr, 32'd0);

    // Full queue with a simultaneous push and pop
    for (int i = 0; i < 8; i++) cycle(1, 32'h10 + 4 * i, 32'(i + 20), 0, 0);
    cycle(1, 32'd200, 32'd55, 1, 0);
    chk("t3.count", 32'(count), 32'd8);
    chk("t3.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0);
    chk("t3.last_addr", last_addr, 32'd200);
    chk("t3.last_data", last_data, 32'd55);

    // Overflow: nine back-to-back stores into an eight-entry queue
    for (int i = 0; i < 9; i++) cycle(1, 32'(4 * i), 32'(i + 1), 0, 0);
    chk("t2.count", 32'(count), 32'd8);
    chk("t2.ovf", 32'(overflow), 32'd1);
    chk("t2.drop", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);

    // Clear takes priority over a coincident store
    chk("t5.pre", 32'(count), 32'd3);
    cycle(1, 32'd8, 32'h77, 0, 1);
    chk("t5.count", 32'(count), 32'd0);
    chk("t5.ovf", 32'(overflow), 32'd0);
    chk("t5.drop", 32'(drop_cnt), 32'd0);

    // Address window filtering on the narrow instance
    wstore(32'd96, 32'd3);
    wstore(32'd104, 32'd25);
    wstore(32'd100, 32'd4);
    chk("t4.count", 32'(wn_count), 32'd2);
    chk("t4.drop", 32'(wn_drop), 32'd0);
    chk("t4.addr0", wn_addr, 32'd96);
    chk("t4.data0", wn_data, 32'd3);
    @(negedge clk);
    wn_ready = 1;
    @(posedge clk);
    #1;
    wn_ready = 0;
    chk("t4.addr1", wn_addr, 32'd100);
    chk("t4.data1", wn_data, 32'd4);
    chk("t4.count1", 32'(wn_count), 32'd1);

    // Asynchronous reset between edges, then a randomized wrap exercise
    for (int i = 0; i < 5; i++) cycle(1, 32'h300 + 4 * i, 32'(i), 0, 0);
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    chk("t6.valid", 32'(out_valid), 32'd0);
    chk("t6.count", 32'(count), 32'd0);
    exp_q.delete();
    m_ovf = 0;
    m_drop = 0;
    @(negedge clk);
    reset = 0;
    cycle(1, 32'd60, 32'd9, 0, 0);
    chk("t6.addr", out_addr, 32'd60);
    chk("t6.data", out_data, 32'd9);
    chk("t6.count1", 32'(count), 32'd1);
    for (int i = 0; i < 20; i++)
      cycle($urandom_range(0, 3) != 0, 32'h400 + 4 * i, $urandom, $urandom_range(0, 1) != 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 0);
    chk("t6.drained", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
